msrv32_dmem_arbiter: RTL and testbench

- Sequences and shares the single data-memory port between two requesters: the core load/store path (store-unit formatted data/mask/address) and a secondary DMA/debug requester.
- Registers the winning request onto the memory port and holds it until the memory acknowledges with wait states. Returns read data and a one-cycle done pulse, and aborts hung transfers with a timeout.
- Sits between the store/load units and the external data-memory interface.

---
 rtl/msrv32_dmem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_msrv32_dmem_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_arbiter.sv
// msrv32_dmem_arbiter: shares the single data-memory port between the core
// load/store path and a secondary DMA/debug requester. The winning request is
// registered onto the memory port and held until the memory acknowledges;
// hung transfers are aborted after TIMEOUT wait-state cycles.
// Build option: define MSRV32_DMEM_RR_EN for round-robin arbitration between
// simultaneous requests; without it the core has fixed priority.
module msrv32_dmem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,

  input  logic             core_req_in,
  input  logic             core_wr_in,
  input  logic [WIDTH-1:0] core_addr_in,
  input  logic [WIDTH-1:0] core_wdata_in,
  input  logic [3:0]       core_mask_in,
  output logic             core_done_out,
  output logic [WIDTH-1:0] core_rdata_out,
  output logic             core_stall_out,

  input  logic             dma_req_in,
  input  logic             dma_wr_in,
  input  logic [WIDTH-1:0] dma_addr_in,
  input  logic [WIDTH-1:0] dma_wdata_in,
  input  logic [3:0]       dma_mask_in,
  output logic             dma_done_out,
  output logic [WIDTH-1:0] dma_rdata_out,

  output logic [WIDTH-1:0] ms_riscv32_mp_dmaddr_out,
  output logic [WIDTH-1:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]       ms_riscv32_mp_dmwr_mask_out,
  output logic             ms_riscv32_mp_dmwr_req_out,
  output logic             ms_riscv32_mp_dmrd_req_out,
  input  logic [WIDTH-1:0] ms_riscv32_mp_dmdata_in,
  input  logic             ms_riscv32_mp_dmready_in,

  output logic             err_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CORE_XFER = 2'd1,
    DMA_XFER  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       mask_q, mask_d;
  logic             wr_req_q, wr_req_d;
  logic             rd_req_q, rd_req_d;
  logic             core_done_q, core_done_d;
  logic             dma_done_q, dma_done_d;
  logic [WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic             err_q, err_d;

  // A requester whose done is pulsing this cycle still holds its request
  // line; it is excluded so the finished transfer is not granted again.
  logic core_elig;
  logic dma_elig;
  logic grant_dma;
  logic win_wr;

`ifdef MSRV32_DMEM_RR_EN
  logic rr_dma_q, rr_dma_d;
`endif

  assign core_elig = core_req_in & ~core_done_q;
  assign dma_elig  = dma_req_in & ~dma_done_q;

`ifdef MSRV32_DMEM_RR_EN
  assign grant_dma = dma_elig & (~core_elig | rr_dma_q);
`else
  assign grant_dma = dma_elig & ~core_elig;
`endif

  assign win_wr = grant_dma ? dma_wr_in : core_wr_in;

  // Next-state logic: arbitration in IDLE, wait-state counting and completion/abort in XFER
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    core_done_d  = 1'b0;
    dma_done_d   = 1'b0;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    err_d        = 1'b0;
`ifdef MSRV32_DMEM_RR_EN
    rr_dma_d     = rr_dma_q;
`endif

    case (state_q)
      IDLE: begin
        if (core_elig || dma_elig) begin
          addr_d   = grant_dma ? dma_addr_in  : core_addr_in;
          wdata_d  = grant_dma ? dma_wdata_in : core_wdata_in;
          mask_d   = win_wr ? (grant_dma ? dma_mask_in : core_mask_in) : 4'b0000;
          wr_req_d = win_wr;
          rd_req_d = ~win_wr;
          cnt_d    = '0;
          state_d  = grant_dma ? DMA_XFER : CORE_XFER;
`ifdef MSRV32_DMEM_RR_EN
          rr_dma_d = ~grant_dma;
`endif
        end
      end

      CORE_XFER, DMA_XFER: begin
        if (ms_riscv32_mp_dmready_in || (cnt_q == CNT_LAST)) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
          if (state_q == DMA_XFER) begin
            dma_done_d = 1'b1;
          end else begin
            core_done_d = 1'b1;
          end
          if (!ms_riscv32_mp_dmready_in) begin
            err_d = 1'b1;
            if (state_q == DMA_XFER) begin
              dma_rdata_d = '0;
            end else begin
              core_rdata_d = '0;
            end
          end else if (rd_req_q) begin
            if (state_q == DMA_XFER) begin
              dma_rdata_d = ms_riscv32_mp_dmdata_in;
            end else begin
              core_rdata_d = ms_riscv32_mp_dmdata_in;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and registered-output flops; reset drops strobes immediately without a done pulse
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= 4'b0000;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      core_done_q  <= 1'b0;
      dma_done_q   <= 1'b0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
      err_q        <= 1'b0;
`ifdef MSRV32_DMEM_RR_EN
      rr_dma_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      core_done_q  <= core_done_d;
      dma_done_q   <= dma_done_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      err_q        <= err_d;
`ifdef MSRV32_DMEM_RR_EN
      rr_dma_q     <= rr_dma_d;
`endif
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = addr_q;
  assign ms_riscv32_mp_dmdata_out    = wdata_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmwr_req_out  = wr_req_q;
  assign ms_riscv32_mp_dmrd_req_out  = rd_req_q;
  assign core_done_out               = core_done_q;
  assign dma_done_out                = dma_done_q;
  assign core_rdata_out              = core_rdata_q;
  assign dma_rdata_out               = dma_rdata_q;
  assign err_out                     = err_q;
  assign core_stall_out              = core_req_in & ~core_done_q;

endmodule

// File: tb/tb_msrv32_dmem_arbiter.sv
// tb_msrv32_dmem_arbiter: randomized scoreboard bench for msrv32_dmem_arbiter.
// A reference model predicts each transfer (grant order, port contents,
// strobe length, read data, abort) from a simple memory array; a responder
// plays the memory with planned wait states; a monitor pops and compares.
module tb_msrv32_dmem_arbiter;

  localparam int WIDTH       = 32;
  localparam int TIMEOUT     = 16;
  localparam int CW          = 5;
  localparam int DONE_BUDGET = 100;

  logic             clk;
  logic             rst_n;
  logic             core_req_in, core_wr_in;
  logic [31:0]      core_addr_in, core_wdata_in;
  logic [3:0]       core_mask_in;
  logic             core_done_out, core_stall_out;
  logic [31:0]      core_rdata_out;
  logic             dma_req_in, dma_wr_in;
  logic [31:0]      dma_addr_in, dma_wdata_in;
  logic [3:0]       dma_mask_in;
  logic             dma_done_out;
  logic [31:0]      dma_rdata_out;
  logic [31:0]      dm_addr, dm_wdata, dm_rdata_in;
  logic [3:0]       dm_mask;
  logic             dm_wr, dm_rd, dm_ready;
  logic             err_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  msrv32_dmem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst_n),
    .core_req_in                 (core_req_in),
    .core_wr_in                  (core_wr_in),
    .core_addr_in                (core_addr_in),
    .core_wdata_in               (core_wdata_in),
    .core_mask_in                (core_mask_in),
    .core_done_out               (core_done_out),
    .core_rdata_out              (core_rdata_out),
    .core_stall_out              (core_stall_out),
    .dma_req_in                  (dma_req_in),
    .dma_wr_in                   (dma_wr_in),
    .dma_addr_in                 (dma_addr_in),
    .dma_wdata_in                (dma_wdata_in),
    .dma_mask_in                 (dma_mask_in),
    .dma_done_out                (dma_done_out),
    .dma_rdata_out               (dma_rdata_out),
    .ms_riscv32_mp_dmaddr_out    (dm_addr),
    .ms_riscv32_mp_dmdata_out    (dm_wdata),
    .ms_riscv32_mp_dmwr_mask_out (dm_mask),
    .ms_riscv32_mp_dmwr_req_out  (dm_wr),
    .ms_riscv32_mp_dmrd_req_out  (dm_rd),
    .ms_riscv32_mp_dmdata_in     (dm_rdata_in),
    .ms_riscv32_mp_dmready_in    (dm_ready),
    .err_out                     (err_out)
  );

  typedef struct {
    bit          en;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          wait_cycles;
  } txn_t;

  typedef struct {
    bit          dma;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    bit          err;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          wait_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] last_rdata [2];
  bit          last_dma_served;

  // Contents of a memory word that has never been written
  function automatic logic [31:0] default_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic txn_t none_txn();
    txn_t t;
    t.en = 1'b0; t.wr = 1'b0; t.addr = '0; t.wdata = '0; t.mask = '0; t.wait_cycles = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r;
    t.en    = 1'b1;
    t.wr    = 1'($urandom_range(0, 1));
    t.addr  = 32'h300 + 32'($urandom_range(0, 7) * 4);
    t.wdata = $urandom;
    t.mask  = 4'($urandom_range(0, 15));
    r = $urandom_range(0, 19);
    if (r == 0)      t.wait_cycles = TIMEOUT + 2;
    else if (r == 1) t.wait_cycles = TIMEOUT - 1;
    else if (r == 2) t.wait_cycles = TIMEOUT;
    else             t.wait_cycles = $urandom_range(0, 4);
    return t;
  endfunction

  // Reference model: one granted transfer, evaluated from the behavioural rules
  function automatic void predict(input bit dma, input txn_t t);
    exp_t        e;
    logic [31:0] word;
    word    = ref_mem.exists(t.addr) ? ref_mem[t.addr] : default_word(t.addr);
    e.dma   = dma;
    e.wr    = t.wr;
    e.addr  = t.addr;
    e.wdata = t.wdata;
    e.mask  = t.wr ? t.mask : 4'b0000;
    e.err   = (t.wait_cycles >= TIMEOUT);
    e.cycles = e.err ? TIMEOUT : t.wait_cycles + 1;
    if (e.err)      last_rdata[dma] = 32'h0;
    else if (!t.wr) last_rdata[dma] = word;
    else            ref_mem[t.addr] = merge_bytes(word, t.wdata, t.mask);
    e.rdata = last_rdata[dma];
    last_dma_served = dma;
    exp_q.push_back(e);
    wait_q.push_back(t.wait_cycles);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hold a requester's request until its done pulse is seen, then release it
  task automatic wait_done(input bit dma);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < DONE_BUDGET && !seen; i++) begin
      @(negedge clk);
      if (dma ? dma_done_out : core_done_out) seen = 1'b1;
    end
    checkOutput(dma ? "dma_done_seen" : "core_done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    if (dma) begin
      dma_req_in = 1'b0; dma_addr_in = $urandom; dma_wdata_in = $urandom;
    end else begin
      core_req_in = 1'b0; core_addr_in = $urandom; core_wdata_in = $urandom;
    end
  endtask

  // Issue one round: core and/or DMA request in the same cycle
  task automatic applyStimulus(input txn_t c, input txn_t d);
    bit first_dma;
    first_dma = 1'b0;
`ifdef MSRV32_DMEM_RR_EN
    first_dma = !last_dma_served;
`endif
    if (c.en && d.en) begin
      if (first_dma) begin predict(1'b1, d); predict(1'b0, c); end
      else           begin predict(1'b0, c); predict(1'b1, d); end
    end else if (c.en) begin
      predict(1'b0, c);
    end else if (d.en) begin
      predict(1'b1, d);
    end
    @(posedge clk);
    #1;
    core_req_in = c.en; core_wr_in = c.wr; core_addr_in = c.addr;
    core_wdata_in = c.wdata; core_mask_in = c.mask;
    dma_req_in = d.en; dma_wr_in = d.wr; dma_addr_in = d.addr;
    dma_wdata_in = d.wdata; dma_mask_in = d.mask;
    fork
      begin if (c.en) wait_done(1'b0); end
      begin if (d.en) wait_done(1'b1); end
    join
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  // Memory responder: completes each transfer after its planned wait states
  initial begin
    int          rsp_cnt;
    int          rsp_wait;
    bit          rsp_active;
    logic [31:0] word;
    rsp_cnt = 0; rsp_wait = 0; rsp_active = 1'b0;
    dm_ready = 1'b0; dm_rdata_in = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_active = 1'b0; rsp_cnt = 0; dm_ready = 1'b0;
        continue;
      end
      if (dm_wr || dm_rd) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_cnt    = 0;
          rsp_wait   = (wait_q.size() > 0) ? wait_q.pop_front() : 1000;
        end else begin
          rsp_cnt++;
        end
        if (rsp_cnt == rsp_wait) begin
          dm_ready = 1'b1;
          word = mem.exists(dm_addr) ? mem[dm_addr] : default_word(dm_addr);
          if (dm_wr) mem[dm_addr] = merge_bytes(word, dm_wdata, dm_mask);
          dm_rdata_in = dm_rd ? word : $urandom;
        end else begin
          dm_ready = 1'b0;
          dm_rdata_in = $urandom;
        end
      end else begin
        rsp_active  = 1'b0;
        dm_ready    = 1'($urandom_range(0, 1));
        dm_rdata_in = $urandom;
      end
    end
  end

  // Monitor: pops expectations at transfer start and checks them at done
  initial begin
    bit   in_xfer, strobe, prev_strobe, prev_elig, prev_done, any_done;
    exp_t cur;
    int   scyc;
    in_xfer = 1'b0; prev_strobe = 1'b0; prev_elig = 1'b0; prev_done = 1'b0; scyc = 0;
    cur.dma = 1'b0; cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0; cur.mask = '0;
    cur.err = 1'b0; cur.rdata = '0; cur.cycles = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_xfer = 1'b0; scyc = 0; prev_strobe = 1'b0; prev_elig = 1'b0; prev_done = 1'b0;
        continue;
      end
      strobe   = dm_wr | dm_rd;
      any_done = core_done_out | dma_done_out;
      checkOutput("core_stall", 32'(core_stall_out), 32'(core_req_in & ~core_done_out));
      if (!prev_strobe && prev_elig) checkOutput("grant_latency", 32'(strobe), 32'd1);
      if (strobe) begin
        checkOutput("strobe_excl", 32'(dm_wr & dm_rd), 32'd0);
        if (!in_xfer) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL xfer_expected: got a transfer at 0x%0h, expected none", dm_addr);
          end else begin
            cur = exp_q.pop_front();
          end
          in_xfer = 1'b1;
          scyc = 0;
        end
        scyc++;
        checkOutput("port_addr", dm_addr, cur.addr);
        checkOutput("port_mask", 32'(dm_mask), 32'(cur.mask));
        checkOutput("port_wr", 32'(dm_wr), 32'(cur.wr));
        if (cur.wr) checkOutput("port_wdata", dm_wdata, cur.wdata);
      end
      if (any_done) begin
        checkOutput("single_done", 32'(core_done_out & dma_done_out), 32'd0);
        checkOutput("done_width", 32'(prev_done), 32'd0);
        checkOutput("done_in_xfer", 32'(in_xfer), 32'd1);
        if (in_xfer) begin
          checkOutput("done_owner", 32'(dma_done_out), 32'(cur.dma));
          checkOutput("rdata", cur.dma ? dma_rdata_out : core_rdata_out, cur.rdata);
          checkOutput("err", 32'(err_out), 32'(cur.err));
          checkOutput("strobe_cycles", 32'(scyc), 32'(cur.cycles));
          checkOutput("strobe_low_at_done", 32'(strobe), 32'd0);
          in_xfer = 1'b0;
        end
      end else if (err_out) begin
        checkOutput("err_alone", 32'(err_out), 32'd0);
      end
      if (in_xfer && !strobe) begin
        checkOutput("strobe_dropped_without_done", 32'(strobe), 32'd1);
        in_xfer = 1'b0;
      end
      prev_strobe = strobe;
      prev_elig   = (core_req_in & ~core_done_out) | (dma_req_in & ~dma_done_out);
      prev_done   = any_done;
    end
  end

  // Safety net so the run always ends
  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    txn_t t, c, d;
    core_req_in = 1'b0; core_wr_in = 1'b0; core_addr_in = '0; core_wdata_in = '0; core_mask_in = '0;
    dma_req_in = 1'b0; dma_wr_in = 1'b0; dma_addr_in = '0; dma_wdata_in = '0; dma_mask_in = '0;
    last_rdata[0] = '0; last_rdata[1] = '0;
    last_dma_served = 1'b1;
    mem[32'h200]     = 32'hDEAD_BEEF;
    ref_mem[32'h200] = 32'hDEAD_BEEF;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_wr", 32'(dm_wr), 32'd0);
    checkOutput("reset_rd", 32'(dm_rd), 32'd0);
    checkOutput("reset_core_done", 32'(core_done_out), 32'd0);
    checkOutput("reset_dma_done", 32'(dma_done_out), 32'd0);
    checkOutput("reset_err", 32'(err_out), 32'd0);
    checkOutput("reset_addr", dm_addr, 32'd0);
    checkOutput("reset_core_rdata", core_rdata_out, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Core store with immediate ready, then core load with three wait states
    t = none_txn(); t.en = 1'b1; t.wr = 1'b1; t.addr = 32'h100; t.wdata = 32'h0000_00AB;
    t.mask = 4'b0001; t.wait_cycles = 0;
    applyStimulus(t, none_txn());
    t.wr = 1'b0; t.addr = 32'h200; t.wait_cycles = 3;
    applyStimulus(t, none_txn());

    // Two collisions in a row
    for (int k = 0; k < 2; k++) begin
      c = rand_txn(); c.wait_cycles = 2;
      d = rand_txn(); d.wait_cycles = 1;
      applyStimulus(c, d);
    end

    // Timeout abort, then a store that must leave the cleared rdata alone
    t = none_txn(); t.en = 1'b1; t.wr = 1'b0; t.addr = 32'h104; t.wait_cycles = TIMEOUT + 4;
    applyStimulus(t, none_txn());
    t.wr = 1'b1; t.wdata = 32'h1234_5678; t.mask = 4'b1111; t.wait_cycles = 0;
    applyStimulus(t, none_txn());
    // Ready arriving on the last allowed cycle completes normally
    t.wr = 1'b0; t.wait_cycles = TIMEOUT - 1;
    applyStimulus(t, none_txn());

    // Reset in the middle of a DMA load
    t = none_txn(); t.en = 1'b1; t.wr = 1'b0; t.addr = 32'h400; t.wait_cycles = 12;
    predict(1'b1, t);
    @(posedge clk);
    #1;
    dma_req_in = 1'b1; dma_wr_in = 1'b0; dma_addr_in = t.addr; dma_wdata_in = $urandom; dma_mask_in = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dm_rd) break;
    end
    checkOutput("pre_reset_rd_strobe", 32'(dm_rd), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rd", 32'(dm_rd), 32'd0);
    checkOutput("async_reset_wr", 32'(dm_wr), 32'd0);
    checkOutput("async_reset_dma_done", 32'(dma_done_out), 32'd0);
    checkOutput("async_reset_core_done", 32'(core_done_out), 32'd0);
    checkOutput("async_reset_err", 32'(err_out), 32'd0);
    dma_req_in = 1'b0;
    exp_q.delete();
    wait_q.delete();
    last_rdata[0] = '0; last_rdata[1] = '0;
    last_dma_served = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Core works normally after reset
    t = none_txn(); t.en = 1'b1; t.wr = 1'b1; t.addr = 32'h500; t.wdata = 32'hCAFE_F00D;
    t.mask = 4'b0110; t.wait_cycles = 1;
    applyStimulus(t, none_txn());
    t.wr = 1'b0; t.wait_cycles = 0;
    applyStimulus(t, none_txn());

    // Randomized rounds: core only, DMA only, or both together
    for (int k = 0; k < 40; k++) begin
      int mode;
      mode = $urandom_range(0, 2);
      c = (mode != 1) ? rand_txn() : none_txn();
      d = (mode != 0) ? rand_txn() : none_txn();
      applyStimulus(c, d);
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
